// File: rtl/mdu_pkg.sv
// Shared multiply/divide unit definitions: funct3 encodings, result-buffer state and entry.
// The overflow flag field exists only when MUL_OVERFLOW_EN is defined.
package mdu_pkg;

  localparam int RES_W = 64;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } mulres_count_t;

  // result is sized for the widest XLEN; narrower builds use the low bits
  typedef struct packed {
    logic [RES_W-1:0] result;
`ifdef MUL_OVERFLOW_EN
    logic             ovf;
`endif
  } mulres_entry_t;

endpackage

// File: rtl/mul_result_select.sv
// Combinational selection/formatting of the multiplier product into a buffer entry.
// Computes the overflow flag as well when MUL_OVERFLOW_EN is defined.
module mul_result_select
  import mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2*XLEN-1:0] prod,
  input  logic [2:0]        funct3,
  input  logic              w64,
  output mulres_entry_t     entry
);

  logic [XLEN-1:0] lo_s;
  logic [XLEN-1:0] hi_s;
  logic [31:0]     lo32_s;
  logic            is_word_s;

  assign lo_s      = prod[XLEN-1:0];
  assign hi_s      = prod[2*XLEN-1:XLEN];
  assign lo32_s    = prod[31:0];
  assign is_word_s = w64 && (XLEN == 64);

  // Pick low half, sign-extended word, or high half; reserved funct3 yields zero
  always_comb begin
    entry = '0;
    case (funct3)
      F3_MUL: begin
        if (is_word_s) begin
          entry.result = {{32{lo32_s[31]}}, lo32_s};
`ifdef MUL_OVERFLOW_EN
          entry.ovf    = (prod[63:32] != {32{lo32_s[31]}});
`endif
        end else begin
          entry.result = RES_W'(lo_s);
`ifdef MUL_OVERFLOW_EN
          entry.ovf    = (hi_s != {XLEN{lo_s[XLEN-1]}});
`endif
        end
      end
      F3_MULH, F3_MULHSU, F3_MULHU: begin
        entry.result = RES_W'(hi_s);
      end
      default: begin
        entry.result = '0;
      end
    endcase
  end

endmodule

// File: rtl/mul_result.sv
// Multiply result stage: formats the product and holds it in an OUT + SKID buffer toward writeback.
// Define MUL_OVERFLOW_EN to add the MulOvfW flag, stored and timed together with the result.
module mul_result
  import mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2*XLEN-1:0] ProdM,
  input  logic [2:0]        Funct3M,
  input  logic              W64M,
  input  logic              ProdValidM,
  output logic              ProdReadyM,
  input  logic              FlushW,
  output logic              ResValidW,
  input  logic              ResReadyW,
  output logic [XLEN-1:0]   MulResultW
`ifdef MUL_OVERFLOW_EN
  ,
  output logic              MulOvfW
`endif
);

  mulres_count_t count_r;
  mulres_entry_t out_r;
  mulres_entry_t skid_r;
  mulres_entry_t sel_s;
  logic          accept_s;
  logic          pop_s;

  mul_result_select #(.XLEN(XLEN)) u_select (
    .prod   (ProdM),
    .funct3 (Funct3M),
    .w64    (W64M),
    .entry  (sel_s)
  );

  // Handshakes depend only on the registered count, never on ResReadyW
  assign ProdReadyM = (count_r != FULL);
  assign ResValidW  = (count_r != EMPTY);
  assign MulResultW = out_r.result[XLEN-1:0];
`ifdef MUL_OVERFLOW_EN
  assign MulOvfW    = out_r.ovf;
`endif

  assign accept_s = ProdValidM & ProdReadyM;
  assign pop_s    = ResValidW & ResReadyW;

  // Two-entry buffer; OUT is cleared whenever it empties so the output reads zero
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= EMPTY;
      out_r   <= '0;
      skid_r  <= '0;
    end else if (FlushW) begin
      count_r <= EMPTY;
      out_r   <= '0;
      skid_r  <= '0;
    end else begin
      case (count_r)
        EMPTY: begin
          if (accept_s) begin
            out_r   <= sel_s;
            count_r <= ONE;
          end
        end
        ONE: begin
          if (accept_s && pop_s) begin
            out_r   <= sel_s;
          end else if (accept_s) begin
            skid_r  <= sel_s;
            count_r <= FULL;
          end else if (pop_s) begin
            out_r   <= '0;
            count_r <= EMPTY;
          end
        end
        FULL: begin
          if (pop_s) begin
            out_r   <= skid_r;
            skid_r  <= '0;
            count_r <= ONE;
          end
        end
        default: begin
          count_r <= EMPTY;
          out_r   <= '0;
          skid_r  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_result.sv
// Self-checking bench for mul_result: directed scenarios plus random traffic against a queue model.
// Checks MulOvfW too when MUL_OVERFLOW_EN is defined.
module tb_mul_result;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] ProdM;
  logic [2:0]   Funct3M;
  logic         W64M;
  logic         ProdValidM;
  logic         ProdReadyM;
  logic         FlushW;
  logic         ResValidW;
  logic         ResReadyW;
  logic [63:0]  MulResultW;
`ifdef MUL_OVERFLOW_EN
  logic         MulOvfW;
`endif

  int total = 0;
  int bad   = 0;

  logic [63:0] q_res[$];
  logic        q_ovf[$];

  always #5 clk = ~clk;

  mul_result #(.XLEN(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .ProdM      (ProdM),
    .Funct3M    (Funct3M),
    .W64M       (W64M),
    .ProdValidM (ProdValidM),
    .ProdReadyM (ProdReadyM),
    .FlushW     (FlushW),
    .ResValidW  (ResValidW),
    .ResReadyW  (ResReadyW),
    .MulResultW (MulResultW)
`ifdef MUL_OVERFLOW_EN
    ,
    .MulOvfW    (MulOvfW)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_res(input logic [127:0] p, input logic [2:0] f3, input logic w);
    logic signed [31:0] lo32;
    lo32 = p[31:0];
    if (f3 == 3'd0) return w ? 64'(lo32) : 64'(p);
    if (f3 <= 3'd3) return 64'(p >> 64);
    return 64'd0;
  endfunction

  function automatic logic ref_ovf(input logic [127:0] p, input logic [2:0] f3, input logic w);
    logic signed [63:0] lo64;
    logic signed [31:0] lo32;
    lo64 = p[63:0];
    lo32 = p[31:0];
    if (f3 != 3'd0) return 1'b0;
    if (w) return $signed(p[63:0]) != 64'(lo32);
    return $signed(p) != 128'(lo64);
  endfunction

  // One clock: advance the model from the applied inputs, then compare all outputs
  task automatic cycle();
    bit          acc;
    bit          pop;
    logic [63:0] r;
    logic        o;
    acc = ProdValidM && (q_res.size() < 2);
    pop = ResReadyW && (q_res.size() > 0);
    r   = ref_res(ProdM, Funct3M, W64M);
    o   = ref_ovf(ProdM, Funct3M, W64M);
    @(posedge clk);
    #1;
    if (!reset || FlushW) begin
      q_res.delete();
      q_ovf.delete();
    end else begin
      if (pop) begin
        void'(q_res.pop_front());
        void'(q_ovf.pop_front());
      end
      if (acc) begin
        q_res.push_back(r);
        q_ovf.push_back(o);
      end
    end
    chk("valid", 64'(ResValidW), 64'(q_res.size() > 0));
    chk("ready", 64'(ProdReadyM), 64'(q_res.size() < 2));
    chk("data", MulResultW, (q_res.size() > 0) ? q_res[0] : 64'd0);
`ifdef MUL_OVERFLOW_EN
    chk("ovf", 64'(MulOvfW), (q_ovf.size() > 0) ? 64'(q_ovf[0]) : 64'd0);
`endif
  endtask

  task automatic offer(input logic [127:0] p, input logic [2:0] f3, input logic w, input logic rdy);
    ProdM      = p;
    Funct3M    = f3;
    W64M       = w;
    ProdValidM = 1'b1;
    ResReadyW  = rdy;
  endtask

  task automatic idle(input logic rdy);
    ProdValidM = 1'b0;
    ResReadyW  = rdy;
  endtask

  initial begin
    reset = 1'b0; FlushW = 1'b0; ProdM = 128'd0; Funct3M = 3'd0; W64M = 1'b0;
    ProdValidM = 1'b0; ResReadyW = 1'b0;
    cycle();
    cycle();
    chk("rst_valid", 64'(ResValidW), 64'd0);
    chk("rst_ready", 64'(ProdReadyM), 64'd1);
    chk("rst_data", MulResultW, 64'd0);
    reset = 1'b1;

    // MULHU returns the high half one cycle later
    offer({64'h1, 64'h2}, 3'b011, 1'b0, 1'b1); cycle();
    chk("mulhu", MulResultW, 64'h1);
    idle(1'b1); cycle();

    // MULW sign-extends the low word
    offer({64'h0, 64'h0000_0000_8000_0000}, 3'b000, 1'b1, 1'b1); cycle();
    chk("mulw", MulResultW, 64'hFFFF_FFFF_8000_0000);
    idle(1'b1); cycle();

    // Backpressure: A, B fill the buffer, C waits upstream
    offer(128'd1, 3'b000, 1'b0, 1'b0); cycle();
    offer(128'd2, 3'b000, 1'b0, 1'b0); cycle();
    chk("bp_full", 64'(ProdReadyM), 64'd0);
    offer(128'd3, 3'b000, 1'b0, 1'b0); cycle();
    chk("bp_hold", MulResultW, 64'd1);
    offer(128'd3, 3'b000, 1'b0, 1'b1); cycle();
    chk("bp_out2", MulResultW, 64'd2);
    cycle();
    chk("bp_out3", MulResultW, 64'd3);
    idle(1'b1); cycle();
    chk("bp_drain", 64'(ResValidW), 64'd0);

    // Flush while FULL drops both entries and the same-cycle offer
    offer(128'd4, 3'b000, 1'b0, 1'b0); cycle();
    offer(128'd5, 3'b000, 1'b0, 1'b0); cycle();
    offer(128'd9, 3'b000, 1'b0, 1'b0); FlushW = 1'b1; cycle();
    FlushW = 1'b0;
    chk("fl_valid", 64'(ResValidW), 64'd0);
    chk("fl_ready", 64'(ProdReadyM), 64'd1);
    idle(1'b1); cycle();
    chk("fl_no9", 64'(ResValidW), 64'd0);

    // Reset while FULL, then normal operation resumes
    offer(128'd6, 3'b000, 1'b0, 1'b0); cycle();
    offer(128'd7, 3'b000, 1'b0, 1'b0); cycle();
    idle(1'b0); reset = 1'b0; FlushW = 1'b1; cycle();
    reset = 1'b1; FlushW = 1'b0;
    chk("mr_valid", 64'(ResValidW), 64'd0);
    chk("mr_data", MulResultW, 64'd0);
    offer(128'd5, 3'b000, 1'b0, 1'b1); cycle();
    chk("mr_five", MulResultW, 64'd5);
    idle(1'b1); cycle();

`ifdef MUL_OVERFLOW_EN
    offer({64'h1, 64'h0}, 3'b000, 1'b0, 1'b1); cycle();
    chk("ovf_mul", 64'(MulOvfW), 64'd1);
    offer({64'h1, 64'h0}, 3'b011, 1'b0, 1'b1); cycle();
    chk("ovf_mulhu", 64'(MulOvfW), 64'd0);
    idle(1'b1); cycle();
`endif

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      ProdM      = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) ProdM[127:64] = {64{ProdM[63]}};
      Funct3M    = 3'($urandom_range(0, 7));
      W64M       = 1'($urandom);
      ProdValidM = 1'($urandom);
      ResReadyW  = ($urandom_range(0, 2) != 0);
      FlushW     = ($urandom_range(0, 29) == 0);
      reset      = ($urandom_range(0, 99) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_result.md
Name: mul_result

Overview:
- M/W-stage consumer of the multiplier's double-width product `ProdM`.
- Selects and formats the architectural result: low half, high half, or sign-extended MULW.
- Buffers results in a 2-entry skid buffer, so writeback backpressure never drops a product.
- Presents a registered result with a valid/ready handshake to writeback.

Parameters:
- XLEN, 64, data width; legal values 32 and 64. Product input width is 2*XLEN.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- ProdM  in  2*XLEN  full product from multiplier
- Funct3M  in  3  multiply type: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
- W64M  in  1  word op (MULW); ignored when XLEN=32
- ProdValidM  in  1  ProdM/Funct3M/W64M valid this cycle
- ProdReadyM  out  1  block can accept a product this cycle
- FlushW  in  1  synchronous flush of all buffered results
- ResValidW  out  1  MulResultW valid
- ResReadyW  in  1  writeback consumes MulResultW this cycle
- MulResultW  out  XLEN  formatted result

Behaviour:
- Transfer rules:
  - Accept = ProdValidM & ProdReadyM.
  - Pop = ResValidW & ResReadyW.
- Selection (combinational, applied before storage):
  - Funct3 000 with W64M=0 -> ProdM[XLEN-1:0].
  - Funct3 000 with W64M=1 (XLEN=64) -> {32{ProdM[31]}, ProdM[31:0]}.
  - Funct3 001/010/011 -> ProdM[2*XLEN-1:XLEN]; W64M is ignored.
  - Funct3 1xx -> result 0; the entry is still accepted.
- Storage:
  - Output register OUT, plus one skid register SKID.
  - State is held as `Count` ∈ {EMPTY, ONE, FULL}.
- Latency: a product accepted in cycle N appears on MulResultW/ResValidW in cycle N+1 if OUT was empty or popped in cycle N.
- Handshakes:
  - ProdReadyM = (Count != FULL); it is registered-derived, never dependent on ResReadyW.
  - ResValidW = (Count != EMPTY).
- Transitions:
  - EMPTY: Accept -> OUT←sel, ONE.
  - ONE:
    - Accept & Pop -> OUT←sel, ONE.
    - Accept & ~Pop -> SKID←sel, FULL.
    - ~Accept & Pop -> EMPTY.
  - FULL: no accept possible.
    - Pop -> OUT←SKID, ONE.
    - Otherwise hold.
- Ordering: strict FIFO; results are never reordered or duplicated.
- Output stability: MulResultW holds its value while ResValidW=1 and ResReadyW=0.
- FlushW=1:
  - Next state is EMPTY.
  - A same-cycle Accept is discarded; flush wins.
  - A same-cycle Pop still counts as consumed by writeback.
- Reset (reset=0), including mid-operation:
  - Count=EMPTY; OUT and SKID cleared to 0.
  - ResValidW=0, MulResultW=0, ProdReadyM=1 from the following cycle.
  - Reset has priority over FlushW.
- MulResultW is 0 whenever Count=EMPTY.

Optional Feature:
- Macro: `MUL_OVERFLOW_EN`.
- With the macro defined:
  - Adds output `MulOvfW` (1 bit).
  - `MulOvfW`=1 when the stored op was MUL (funct3 000, W64M=0) and ProdM[2*XLEN-1:XLEN] != {XLEN{ProdM[XLEN-1]}}.
  - For MULW (XLEN=64), `MulOvfW`=1 when ProdM[63:32] != {32{ProdM[31]}}.
  - Otherwise 0.
  - The flag is stored alongside the result in OUT/SKID and follows identical timing, flush and reset behaviour (0 on reset/empty).
- Without the macro: the port and its storage are absent; behaviour is otherwise identical.

Decomposition:
- Package `mdu_pkg`:
  - Funct3 multiply encodings: MUL, MULH, MULHSU, MULHU.
  - Enum `mulres_count_t` {EMPTY, ONE, FULL}.
  - Struct `mulres_entry_t` {result, ovf under macro}.
- Sub-module `mul_result_select`: pure combinational ProdM/Funct3M/W64M -> entry, instantiated once ahead of the buffer.

Test Plan:
- MULHU: ProdM = upper 64'h1, lower 64'h2; Funct3M=011; ProdValidM=1; ResReadyW=1 -> next cycle ResValidW=1, MulResultW=64'h1.
- MULW: ProdM lower = 64'h0000_0000_8000_0000; Funct3M=000; W64M=1 -> MulResultW=64'hFFFF_FFFF_8000_0000.
- Backpressure: ResReadyW=0; offer A=1, B=2, C=3 (MUL low halves) on consecutive cycles.
  - ProdReadyM=0 after B is accepted; C is held upstream.
  - Raise ResReadyW -> outputs 1, 2, 3 in order with no gaps once C is accepted.
- Flush: FULL with A, B; FlushW=1 with ProdValidM=1 (value 9) -> next cycle ResValidW=0, ProdReadyM=1, and 9 is never emitted.
- Reset mid-operation: FULL, then reset=0 for one cycle -> ResValidW=0, MulResultW=0, ProdReadyM=1; a subsequent MUL of 5 emits 5.
- `MUL_OVERFLOW_EN`, MUL: ProdM = upper 64'h1, lower 64'h0 -> MulOvfW=1. Same upper/lower with Funct3M=011 -> MulOvfW=0.
